inst_pipe: RTL and testbench

- Instruction-word pipeline register chain: IF/ID, ID/EX, EX/M, M/WB.
- Produces the stage instruction words inst_ex, inst_m and inst_wb that the forwarding unit consumes.
- Detects load-use hazards that forwarding cannot cover and inserts bubbles.
- Applies branch flushes and memory-busy freezes, and drives the stall signal to the PC/fetch logic.

---
 rtl/inst_pipe.sv | 119 +++++++++++
 tb/tb_inst_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/inst_pipe.sv
// Instruction-word pipeline IF/ID -> ID/EX -> EX/M -> M/WB with load-use bubbles,
// branch flush (deferred across mem_busy) and freeze. Optional perf counters: INST_PIPE_PERF_CNT_EN.
module inst_pipe #(
  parameter logic [15:0] NOP_WORD  = 16'h0000,
  parameter logic [3:0]  LOAD_OP_A = 4'b1010,
  parameter logic [3:0]  LOAD_OP_B = 4'b1100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inst_if,
  input  logic        if_valid,
  input  logic        flush,
  input  logic        mem_busy,
  output logic [15:0] inst_id,
  output logic [15:0] inst_ex,
  output logic [15:0] inst_m,
  output logic [15:0] inst_wb,
  output logic        stall,
  output logic        flush_pending
`ifdef INST_PIPE_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE
  } action_t;

  action_t action;
  logic    eff_flush;
  logic    load_use;
  logic    ex_is_load;
  logic    op1_hit;
  logic    op2_hit;

  function automatic logic reads_op1(input logic [3:0] op);
    return (op[3:1] == 3'b100) || (op[3:1] == 3'b010) || (op == 4'b0110) ||
           (op == 4'b1111)     || (op[3:1] == 3'b101) || (op[3:1] == 3'b110);
  endfunction

  function automatic logic reads_op2(input logic [3:0] op);
    return (op == 4'b1111) || (op[3:1] == 3'b101) || (op[3:1] == 3'b110);
  endfunction

  always_comb begin
    ex_is_load = (inst_ex[15:12] == LOAD_OP_A) || (inst_ex[15:12] == LOAD_OP_B);
    op1_hit    = reads_op1(inst_id[15:12]) && (inst_id[11:8] == inst_ex[11:8]);
    op2_hit    = reads_op2(inst_id[15:12]) && (inst_id[7:4]  == inst_ex[11:8]);
    load_use   = ex_is_load && (op1_hit || op2_hit);
    eff_flush  = flush | flush_pending;
    stall      = mem_busy | (load_use & ~eff_flush);
  end

  always_comb begin
    action = ACT_ADVANCE;
    if (mem_busy)       action = ACT_HOLD;
    else if (eff_flush) action = ACT_FLUSH;
    else if (load_use)  action = ACT_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_id <= NOP_WORD;
      inst_ex <= NOP_WORD;
      inst_m  <= NOP_WORD;
      inst_wb <= NOP_WORD;
    end else begin
      case (action)
        ACT_HOLD: ;
        ACT_FLUSH: begin
          inst_id <= NOP_WORD;
          inst_ex <= NOP_WORD;
          inst_m  <= inst_ex;
          inst_wb <= inst_m;
        end
        ACT_BUBBLE: begin
          inst_ex <= NOP_WORD;
          inst_m  <= inst_ex;
          inst_wb <= inst_m;
        end
        default: begin
          inst_id <= if_valid ? inst_if : NOP_WORD;
          inst_ex <= inst_id;
          inst_m  <= inst_ex;
          inst_wb <= inst_m;
        end
      endcase
    end
  end

  // A flush arriving while frozen is remembered and applied on the first non-busy edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pending <= 1'b0;
    end else if (mem_busy) begin
      if (flush) flush_pending <= 1'b1;
    end else if (eff_flush) begin
      flush_pending <= 1'b0;
    end
  end

`ifdef INST_PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (action == ACT_BUBBLE && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      if (action == ACT_FLUSH  && flush_cnt != '1) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_pipe.sv
// Directed bench for inst_pipe: reset, load-use bubbles, flush priority,
// deferred flush across mem_busy, and (with INST_PIPE_PERF_CNT_EN) perf counters.
module tb_inst_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] inst_if;
  logic        if_valid;
  logic        flush;
  logic        mem_busy;
  logic [15:0] inst_id, inst_ex, inst_m, inst_wb;
  logic        stall, flush_pending;
`ifdef INST_PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  inst_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_if      (inst_if),
    .if_valid     (if_valid),
    .flush        (flush),
    .mem_busy     (mem_busy),
    .inst_id      (inst_id),
    .inst_ex      (inst_ex),
    .inst_m       (inst_m),
    .inst_wb      (inst_wb),
    .stall        (stall),
    .flush_pending(flush_pending)
`ifdef INST_PIPE_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [15:0] id, input logic [15:0] ex,
                          input logic [15:0] m, input logic [15:0] wb);
    chk({tag, ".id"}, inst_id, id);
    chk({tag, ".ex"}, inst_ex, ex);
    chk({tag, ".m"},  inst_m,  m);
    chk({tag, ".wb"}, inst_wb, wb);
  endtask

  initial begin
    rst_n = 1'b1; inst_if = 16'h0000; if_valid = 1'b0; flush = 1'b0; mem_busy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_regs("rst0", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("rst0.stall", {15'd0, stall}, 16'h0);
    chk("rst0.fp", {15'd0, flush_pending}, 16'h0);
`ifdef INST_PIPE_PERF_CNT_EN
    chk("rst0.stall_cnt", stall_cnt, 16'h0);
    chk("rst0.flush_cnt", flush_cnt, 16'h0);
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Load-use on op1
    if_valid = 1'b1; inst_if = 16'hC320; tick();
    inst_if = 16'hF341; tick();
    chk_regs("lu.setup", 16'hF341, 16'hC320, 16'h0000, 16'h0000);
    chk("lu.stall", {15'd0, stall}, 16'h1);
    inst_if = 16'h1111; tick();
    chk_regs("lu.bubble", 16'hF341, 16'h0000, 16'hC320, 16'h0000);
    chk("lu.bubble.stall", {15'd0, stall}, 16'h0);
    if_valid = 1'b0; tick();
    chk_regs("lu.resume", 16'h0000, 16'hF341, 16'h0000, 16'hC320);
    chk("lu.resume.stall", {15'd0, stall}, 16'h0);

    // No hazard: 8153 reads only op1 (r1)
    if_valid = 1'b1; inst_if = 16'hA500; tick();
    inst_if = 16'h8153; tick();
    chk("nohaz.ex", inst_ex, 16'hA500);
    chk("nohaz.stall", {15'd0, stall}, 16'h0);
    // Op2 hazard: F153 reads r5 as op2
    inst_if = 16'hA500; tick();
    inst_if = 16'hF153; tick();
    chk_regs("op2.setup", 16'hF153, 16'hA500, 16'h8153, 16'hA500);
    chk("op2.stall", {15'd0, stall}, 16'h1);
    if_valid = 1'b0; tick();
    chk_regs("op2.bubble", 16'hF153, 16'h0000, 16'hA500, 16'h8153);
    tick();
    chk_regs("op2.resume", 16'h0000, 16'hF153, 16'h0000, 16'hA500);

    // Flush overrides load-use
    if_valid = 1'b1; inst_if = 16'hC320; tick();
    inst_if = 16'hF341; tick();
    chk("fl.stall_pre", {15'd0, stall}, 16'h1);
    flush = 1'b1;
    #1;
    chk("fl.stall", {15'd0, stall}, 16'h0);
    tick();
    flush = 1'b0;
    chk_regs("fl.after", 16'h0000, 16'h0000, 16'hC320, 16'h0000);
    chk("fl.fp", {15'd0, flush_pending}, 16'h0);

    // Fill, then flush during a 3-cycle freeze
    inst_if = 16'h1234; tick();
    inst_if = 16'h5678; tick();
    inst_if = 16'h9ABC; tick();
    inst_if = 16'h0DEF; tick();
    chk_regs("busy.fill", 16'h0DEF, 16'h9ABC, 16'h5678, 16'h1234);
    mem_busy = 1'b1; flush = 1'b1; inst_if = 16'h7777;
    #1;
    chk("busy.stall", {15'd0, stall}, 16'h1);
    tick();
    flush = 1'b0;
    chk("busy.fp1", {15'd0, flush_pending}, 16'h1);
    tick();
    tick();
    chk_regs("busy.frozen", 16'h0DEF, 16'h9ABC, 16'h5678, 16'h1234);
    chk("busy.fp3", {15'd0, flush_pending}, 16'h1);
    mem_busy = 1'b0;
    #1;
    chk("busy.release.stall", {15'd0, stall}, 16'h0);
    tick();
    chk_regs("busy.flushed", 16'h0000, 16'h0000, 16'h9ABC, 16'h5678);
    chk("busy.fp_clr", {15'd0, flush_pending}, 16'h0);

    // Asynchronous reset mid-stream
    inst_if = 16'h1111; tick();
    inst_if = 16'h2222; tick();
    inst_if = 16'h3333; tick();
    inst_if = 16'h4444; tick();
    chk_regs("mid.fill", 16'h4444, 16'h3333, 16'h2222, 16'h1111);
    rst_n = 1'b0;
    #2;
    chk_regs("mid.rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("mid.rst.stall", {15'd0, stall}, 16'h0);
    #2 rst_n = 1'b1;
    inst_if = 16'hF341; tick();
    chk_regs("mid.first", 16'hF341, 16'h0000, 16'h0000, 16'h0000);

`ifdef INST_PIPE_PERF_CNT_EN
    chk("perf.rst.stall_cnt", stall_cnt, 16'h0);
    for (int i = 0; i < 3; i++) begin
      inst_if = 16'hC320; tick();
      inst_if = 16'hF341; tick();
      tick();
    end
    chk("perf.stall_cnt3", stall_cnt, 16'd3);
    for (int i = 0; i < 2; i++) begin
      flush = 1'b1; tick();
      flush = 1'b0; tick();
    end
    chk("perf.flush_cnt2", flush_cnt, 16'd2);
    chk("perf.stall_cnt_keep", stall_cnt, 16'd3);
    force dut.load_use = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    release dut.load_use;
    chk("perf.stall_sat", stall_cnt, 16'hFFFF);
    chk("perf.flush_keep", flush_cnt, 16'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
